// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// DMEM_ARB_FIXED_PRIO_EN selects fixed loader-first priority instead of round-robin.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MEM_LAT_DEF = 1;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned F3_W        = 3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant; round-robin by default,
// loader-first fixed priority when DMEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0_c,
  output logic gnt1_c
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (valid0 && valid1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gnt1_c = 1'b1;
`else
      // Tie goes to the port not granted last.
      if (last_grant == PORT_CPU) gnt1_c = 1'b1;
      else                        gnt0_c = 1'b1;
`endif
    end else begin
      gnt0_c = valid0;
      gnt1_c = valid1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (port 0) and the loader (port 1).
// Build option: DMEM_ARB_FIXED_PRIO_EN (fixed loader-first priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [F3_W-1:0]   req0_funct3,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [F3_W-1:0]   req1_funct3,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [F3_W-1:0]   mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [F3_W-1:0]   funct3_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last_grant_q;
  logic              gnt0_c, gnt1_c;
  logic              accept_c;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt0_c     (gnt0_c),
    .gnt1_c     (gnt1_c)
  );

  assign accept_c = (state_q == IDLE) && (gnt0_c || gnt1_c);

  // Next state, handshake and memory/response outputs, all decoded from registered state.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0_c;
        req1_ready = gnt1_c;
        if (accept_c) state_d = ACCESS;
      end
      ACCESS: begin
        mem_read   = !we_q;
        mem_write  = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_funct3 = funct3_q;
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        if (port_q == PORT_LDR) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = rdata_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request latch and grant history, loaded on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      last_grant_q <= PORT_LDR;
    end else if (accept_c) begin
      port_q       <= gnt1_c ? PORT_LDR : PORT_CPU;
      last_grant_q <= gnt1_c ? PORT_LDR : PORT_CPU;
      we_q         <= gnt1_c ? req1_we     : req0_we;
      addr_q       <= gnt1_c ? req1_addr   : req0_addr;
      wdata_q      <= gnt1_c ? req1_wdata  : req0_wdata;
      funct3_q     <= gnt1_c ? req1_funct3 : req0_funct3;
    end
  end

  // Latency counter and read capture on the final ACCESS cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (accept_c) begin
      cnt_q <= CNT_W'(MEM_LAT - 1);
    end else if (state_q == ACCESS) begin
      if (cnt_q != '0) cnt_q   <= cnt_q - CNT_W'(1);
      else             rdata_q <= we_q ? '0 : mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory load/store port between the CPU datapath (port 0) and an external program loader/debug master (port 1). Each requester uses a valid/ready request handshake and receives a one-cycle response pulse carrying read data. The block sits between the requesters and the byte/half/word memory wrapper. It stalls whichever requester is not granted, and sequences each access through a fixed accept → access → respond cycle.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1, range 1–15: cycles that memory strobes are held before read data is sampled.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1: access request.
- `req0_ready`, `req1_ready`  out  1: request accepted this cycle.
- `req0_we`, `req1_we`  in  1: 1 = store, 0 = load.
- `req0_addr`, `req1_addr`  in  ADDR_W: byte address.
- `req0_wdata`, `req1_wdata`  in  DATA_W: store data.
- `req0_funct3`, `req1_funct3`  in  3: access size/sign code, passed to memory unchanged.
- `rsp0_valid`, `rsp1_valid`  out  1: one-cycle completion pulse, for both loads and stores.
- `rsp0_rdata`, `rsp1_rdata`  out  DATA_W: load data, valid only with `rspN_valid`.
- `mem_read`, `mem_write`  out  1: memory strobes.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_funct3`  out  3: memory access size/sign code.
- `mem_rdata`  in  DATA_W: memory read data, combinational from `mem_addr`.

## Operation
- States:
  - IDLE: arbitrate; `reqN_ready` is driven combinationally for the winner only.
  - ACCESS: strobes driven from registered request fields.
  - RESP: response pulse.
- IDLE → ACCESS: on `valid && ready`, the request fields (port id, we, addr, wdata, funct3) are latched.
- ACCESS → RESP: after `MEM_LAT` cycles, counted by a 4-bit down-counter loaded with `MEM_LAT-1`.
- RESP → IDLE: unconditionally.
- Arbitration is round-robin.
  - If both ports are valid in IDLE, the port not granted last wins.
  - If only one port is valid, it wins regardless of history.
  - `last_grant` updates on every accept.
- Strobes in ACCESS:
  - A load drives `mem_read=1`, `mem_write=0`.
  - A store drives `mem_write=1`, `mem_read=0`.
  - `mem_addr`, `mem_wdata` and `mem_funct3` come from the latched request.
- Read capture: `mem_rdata` is registered on the last ACCESS cycle. For stores, the capture register is loaded with 0.
- Response routing: `rspN_valid` pulses only for the latched port. The other port's `rsp_valid` stays 0 and its `rsp_rdata` stays 0.
- Outside ACCESS, all `mem_*` outputs are 0.
- Requester rules:
  - Request fields must stay stable while `valid && !ready`.
  - Dropping `valid` before acceptance is legal and causes no access.
- No request is accepted outside IDLE: both `ready` outputs are 0 in ACCESS and RESP.

## Timing
- Reset values:
  - State IDLE; all `ready`, `rsp*`, `mem_*` outputs 0; capture register 0.
  - `last_grant` = 1, so port 0 wins the first tie.
- Accept in cycle T:
  - ACCESS spans T+1 .. T+MEM_LAT.
  - `rspN_valid` is high in T+MEM_LAT+1.
  - The next accept is possible in T+MEM_LAT+2.
- Throughput: one access per `MEM_LAT+2` cycles.
- A store commits on the memory's clock edge at the end of the last ACCESS cycle.
- Reset mid-operation:
  - Returns to IDLE asynchronously; strobes drop immediately.
  - No response is issued.
  - The in-flight store may or may not have committed; requesters must reissue.
- Simultaneous events:
  - A new request arriving during RESP waits for IDLE.
  - A tie is resolved in the same cycle it appears.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority, with port 1 (loader) always winning ties. `last_grant` is unused and port 0 may starve.
- Not defined: round-robin as above.

## Structure
- Shared package `dmem_arb_pkg` contains:
  - State enum `arb_state_t` (IDLE, ACCESS, RESP).
  - Port-id constants `PORT_CPU=0`, `PORT_LDR=1`.
  - Default widths.
- One sub-module, `rr_arb2`: combinational 2-way grant from the two valids, `last_grant`, and the priority macro.
- Top level holds the FSM, latency counter, request latch and response routing.

## Test plan
- Single CPU load, `MEM_LAT=1`: `req0_valid` with addr 0x10, memory returns 0xDEADBEEF.
  - `req0_ready` in T, `mem_read` in T+1, `rsp0_valid` with 0xDEADBEEF in T+2.
  - Port 1 outputs stay 0 throughout.
- Tie after reset: both ports valid in the same cycle, both stores.
  - Port 0 is granted first and port 1 next, with accepts 3 cycles apart.
  - Memory sees port 0's data, then port 1's.
- Sustained contention over 10 accesses: both ports always valid.
  - Grants alternate 0,1,0,1…
  - With `DMEM_ARB_FIXED_PRIO_EN` defined, all 10 grants go to port 1.
- `MEM_LAT=3`, loader load at addr 0x40.
  - `mem_read` high for exactly 3 cycles.
  - `rsp1_valid` in T+4, carrying data sampled on the 3rd ACCESS cycle.
- Reset mid-operation: assert `rst=0` during ACCESS of a store.
  - `mem_write` drops without waiting for a clock edge; no `rsp` pulse.
  - After release, the first tie goes to port 0.
- Withdrawn request: `req1_valid` high for one cycle while the block is busy, then low.
  - No access is issued for port 1.
  - `rsp1_valid` never pulses.
